// File: rtl/fp_inv_sqrt_arbiter.sv
// Round-robin arbiter that shares one folded inverse-sqrt unit among NUM_REQ
// requesters, with a non-positive-operand bypass and a WAIT watchdog.
module fp_inv_sqrt_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [NUM_REQ-1:0]            resp_valid_out,
  output logic [DATA_WIDTH-1:0]         resp_data_out,
  input  logic [NUM_REQ-1:0]            resp_ready_in,
  output logic [DATA_WIDTH-1:0]         isq_a_out,
  output logic                          isq_valid_out,
  input  logic                          isq_ready_in,
  input  logic [DATA_WIDTH-1:0]         isq_res_in,
  input  logic                          isq_valid_in,
  output logic                          busy_out,
  output logic                          timeout_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] operand_q, operand_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

  logic                  found_s;
  logic [IDX_W-1:0]      cand_s;
  logic [IDX_W-1:0]      pick_s;
  logic [DATA_WIDTH-1:0] pick_data_s;
  logic                  bypass_s;
  logic                  accept_s;

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting one past the previous grant.
  always_comb begin
    found_s = 1'b0;
    cand_s  = last_grant_q;
    pick_s  = last_grant_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found_s && req_valid_in[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    pick_data_s = req_data_in[int'(pick_s)*DATA_WIDTH +: DATA_WIDTH];
    bypass_s    = pick_data_s[DATA_WIDTH-1] || (pick_data_s == '0);
  end

  // Next-state logic for the operation sequencer and watchdog.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    operand_d    = operand_q;
    result_d     = result_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    accept_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_s && isq_ready_in) begin
          accept_s     = 1'b1;
          grant_d      = pick_s;
          last_grant_d = pick_s;
          operand_d    = pick_data_s;
          cnt_d        = '0;
          if (bypass_s) begin
            result_d = SAT_MAX;
            state_d  = S_RESP;
          end else begin
            state_d  = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (isq_valid_in) begin
          result_d = isq_res_in;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready_in[grant_q]) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_IDX;
      operand_q    <= '0;
      result_q     <= '0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      operand_q    <= operand_d;
      result_q     <= result_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // The accept pulse is combinational, so it is masked while reset is held.
  always_comb begin
    req_ready_out  = (accept_s && !rst_in) ? to_onehot(pick_s) : '0;
    resp_valid_out = (state_q == S_RESP) ? to_onehot(grant_q) : '0;
    resp_data_out  = (state_q == S_RESP) ? result_q : '0;
    isq_valid_out  = (state_q == S_ISSUE);
    isq_a_out      = (state_q == S_ISSUE) ? operand_q : '0;
    busy_out       = (state_q != S_IDLE);
    timeout_out    = timeout_q;
  end

endmodule

// File: tb/tb_fp_inv_sqrt_arbiter.sv
// Directed bench for fp_inv_sqrt_arbiter: the unit side is driven by hand.
module tb_fp_inv_sqrt_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  resp_valid;
  logic [DW-1:0]  resp_data;
  logic [NR-1:0]  resp_ready;
  logic [DW-1:0]  isq_a;
  logic           isq_vout;
  logic           isq_ready;
  logic [DW-1:0]  isq_res;
  logic           isq_vin;
  logic           busy;
  logic           tmo;

  int vec_cnt = 0;
  int err_cnt = 0;

  fp_inv_sqrt_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid), .req_data_in(req_data), .req_ready_out(req_ready),
    .resp_valid_out(resp_valid), .resp_data_out(resp_data), .resp_ready_in(resp_ready),
    .isq_a_out(isq_a), .isq_valid_out(isq_vout), .isq_ready_in(isq_ready),
    .isq_res_in(isq_res), .isq_valid_in(isq_vin),
    .busy_out(busy), .timeout_out(tmo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_data = {4{32'h0001_0000}};
    resp_ready = 4'b1111; isq_ready = 1'b1; isq_res = 32'h1234_5678; isq_vin = 1'b1;
    step(); step();
    vec_cnt++;
    if ({req_ready, resp_valid, resp_data, isq_a, isq_vout, busy, tmo} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got rr=%b rv=%b rd=%h a=%h iv=%b busy=%b tmo=%b, want all 0",
               req_ready, resp_valid, resp_data, isq_a, isq_vout, busy, tmo);
    end
    rst = 1'b0; req_valid = '0; resp_ready = '0; isq_vin = 1'b0;
  endtask

  task automatic test_fairness();
    logic [NR-1:0] exp_oh;
    req_valid = 4'b1111; req_data = {4{32'h0001_0000}};
    for (int n = 0; n < 5; n++) begin
      exp_oh = 4'(1 << (n % 4));
      #1;
      vec_cnt++;
      if (req_ready !== exp_oh) begin
        err_cnt++; $display("FAIL fair_grant%0d: got %b want %b", n, req_ready, exp_oh);
      end
      step();
      vec_cnt++;
      if (isq_vout !== 1'b1 || isq_a !== 32'h0001_0000 || req_ready !== 4'b0000) begin
        err_cnt++; $display("FAIL fair_issue%0d: got v=%b a=%h rr=%b want 1 00010000 0000", n, isq_vout, isq_a, req_ready);
      end
      step();
      isq_vin = 1'b1; isq_res = 32'h0001_0000;
      step();
      isq_vin = 1'b0;
      vec_cnt++;
      if (resp_valid !== exp_oh || resp_data !== 32'h0001_0000) begin
        err_cnt++; $display("FAIL fair_resp%0d: got %b/%h want %b/00010000", n, resp_valid, resp_data, exp_oh);
      end
      resp_ready = 4'b1111;
      step();
      resp_ready = 4'b0000;
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    isq_ready = 1'b0; req_valid = 4'b0001; req_data = {96'h0, 32'h0000_8000};
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0000) begin
      err_cnt++; $display("FAIL stall_ready: got %b want 0000", req_ready);
    end
    step();
    vec_cnt++;
    if (busy !== 1'b0 || req_ready !== 4'b0000) begin
      err_cnt++; $display("FAIL stall_busy: got busy=%b rr=%b want 0 0000", busy, req_ready);
    end
    isq_ready = 1'b1;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++; $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    vec_cnt++;
    if (isq_vout !== 1'b1 || isq_a !== 32'h0000_8000 || busy !== 1'b1) begin
      err_cnt++; $display("FAIL single_issue: got v=%b a=%h busy=%b want 1 00008000 1", isq_vout, isq_a, busy);
    end
    step();
    vec_cnt++;
    if (isq_vout !== 1'b0) begin
      err_cnt++; $display("FAIL single_one_pulse: got %b want 0", isq_vout);
    end
    repeat (18) step();
    vec_cnt++;
    if (resp_valid !== 4'b0000) begin
      err_cnt++; $display("FAIL single_early: got %b want 0000", resp_valid);
    end
    isq_vin = 1'b1; isq_res = 32'h0001_6A0A;
    step();
    isq_vin = 1'b0; isq_res = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (resp_valid !== 4'b0001 || resp_data !== 32'h0001_6A0A) begin
        err_cnt++; $display("FAIL single_resp%0d: got %b/%h want 0001/00016a0a", i, resp_valid, resp_data);
      end
      step();
    end
    resp_ready = 4'b0001;
    step();
    resp_ready = '0;
    vec_cnt++;
    if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL single_done: got rv=%b busy=%b want 0000 0", resp_valid, busy);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] ops [2];
    ops[0] = 32'h0000_0000;
    ops[1] = 32'hFFFF_0000;
    for (int n = 0; n < 2; n++) begin
      req_valid = 4'b0100; req_data = {32'h0, ops[n], 64'h0};
      #1;
      vec_cnt++;
      if (req_ready !== 4'b0100) begin
        err_cnt++; $display("FAIL bypass_grant%0d: got %b want 0100", n, req_ready);
      end
      step();
      req_valid = '0;
      vec_cnt++;
      if (isq_vout !== 1'b0 || resp_valid !== 4'b0100 || resp_data !== 32'h7FFF_FFFF) begin
        err_cnt++; $display("FAIL bypass_resp%0d: got iv=%b rv=%b rd=%h want 0 0100 7fffffff", n, isq_vout, resp_valid, resp_data);
      end
      resp_ready = 4'b0100;
      step();
      resp_ready = '0;
    end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0010; req_data = {64'h0, 32'h0004_0000, 32'h0};
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0010) begin
      err_cnt++; $display("FAIL bp_grant: got %b want 0010", req_ready);
    end
    step();
    req_valid = '0;
    step();
    isq_vin = 1'b1; isq_res = 32'h0000_8000;
    step();
    isq_vin = 1'b0; isq_res = 32'h0;
    resp_ready = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      vec_cnt++;
      if (resp_valid !== 4'b0010 || resp_data !== 32'h0000_8000) begin
        err_cnt++; $display("FAIL bp_hold%0d: got %b/%h want 0010/00008000", i, resp_valid, resp_data);
      end
      step();
    end
    resp_ready = 4'b0010;
    step();
    resp_ready = '0;
    vec_cnt++;
    if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL bp_release: got rv=%b busy=%b want 0000 0", resp_valid, busy);
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    req_valid = 4'b1000; req_data = {32'h0001_0000, 96'h0};
    #1;
    vec_cnt++;
    if (req_ready !== 4'b1000) begin
      err_cnt++; $display("FAIL tmo_grant: got %b want 1000", req_ready);
    end
    step();
    req_valid = '0;
    step();
    for (int i = 1; i < TMO; i++) begin
      step();
      if (tmo !== 1'b0 || busy !== 1'b1) early++;
    end
    vec_cnt++;
    if (early != 0) begin
      err_cnt++; $display("FAIL tmo_early: got %0d bad WAIT cycles want 0", early);
    end
    step();
    vec_cnt++;
    if (tmo !== 1'b1 || busy !== 1'b0 || resp_valid !== 4'b0000) begin
      err_cnt++; $display("FAIL tmo_pulse: got tmo=%b busy=%b rv=%b want 1 0 0000", tmo, busy, resp_valid);
    end
    isq_vin = 1'b1; isq_res = 32'h0002_0000;
    step();
    isq_vin = 1'b0;
    vec_cnt++;
    if (tmo !== 1'b0) begin
      err_cnt++; $display("FAIL tmo_single: got %b want 0", tmo);
    end
    step();
    vec_cnt++;
    if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL tmo_late: got rv=%b busy=%b want 0000 0", resp_valid, busy);
    end
  endtask

  task automatic test_reset_in_wait();
    req_valid = 4'b0010; req_data = {64'h0, 32'h0001_0000, 32'h0};
    step();
    req_valid = '0;
    step();
    vec_cnt++;
    if (busy !== 1'b1 || isq_vout !== 1'b0) begin
      err_cnt++; $display("FAIL rw_in_wait: got busy=%b iv=%b want 1 0", busy, isq_vout);
    end
    #2;
    rst = 1'b1; req_valid = 4'b1111;
    #1;
    vec_cnt++;
    if ({req_ready, resp_valid, resp_data, isq_a, isq_vout, busy, tmo} !== '0) begin
      err_cnt++; $display("FAIL rw_abort: got rr=%b rv=%b busy=%b tmo=%b want all 0", req_ready, resp_valid, busy, tmo);
    end
    step();
    rst = 1'b0; req_valid = '0; isq_vin = 1'b1; isq_res = 32'h0003_0000;
    step();
    isq_vin = 1'b0;
    vec_cnt++;
    if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL rw_stray: got rv=%b busy=%b want 0000 0", resp_valid, busy);
    end
    req_valid = 4'b1111; req_data = {4{32'h0001_0000}};
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++; $display("FAIL rw_first_grant: got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_bypass();
    test_backpressure();
    test_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fp_inv_sqrt_arbiter.md
FP_INV_SQRT_ARBITER -- requirements
Module: fp_inv_sqrt_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requester ports.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the operand/result width in Q16.16 fixed point.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum WAIT cycles before abort.
REQ-004 clk_in  input  1  system clock; all state updates on the rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 req_valid_in  input  NUM_REQ  per-requester operand valid.
REQ-007 req_data_in  input  NUM_REQ*DATA_WIDTH  packed operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready_out  output  NUM_REQ  one-hot single-cycle accept pulse.
REQ-009 resp_valid_out  output  NUM_REQ  one-hot result valid to the granted requester.
REQ-010 resp_data_out  output  DATA_WIDTH  shared result bus, valid only with resp_valid_out.
REQ-011 resp_ready_in  input  NUM_REQ  per-requester result acknowledge.
REQ-012 isq_a_out  output  DATA_WIDTH  operand to the shared folded inverse-sqrt unit.
REQ-013 isq_valid_out  output  1  start pulse to the unit.
REQ-014 isq_ready_in  input  1  unit idle/ready.
REQ-015 isq_res_in  input  DATA_WIDTH  unit result.
REQ-016 isq_valid_in  input  1  unit result valid.
REQ-017 busy_out  output  1  high in every state except IDLE.
REQ-018 timeout_out  output  1  single-cycle pulse on watchdog abort.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; reset enters IDLE.
REQ-020 IDLE: when any req_valid_in bit is set and isq_ready_in=1, the block SHALL grant the first requesting index searching upward from (last_grant+1) mod NUM_REQ, pulse req_ready_out[g] that cycle, latch the operand and g, and set last_grant=g.
REQ-021 IDLE with isq_ready_in=0 SHALL accept nothing; pending requests stay pending with no ordering penalty.
REQ-022 A latched operand <= 0 (signed) SHALL bypass the unit: next state RESP with result 32'h7FFFFFFF.
REQ-023 A positive operand SHALL go to ISSUE, which drives isq_valid_out=1 with isq_a_out=operand for exactly one cycle, then WAIT.
REQ-024 WAIT SHALL latch isq_res_in on the first cycle isq_valid_in=1 and move to RESP on the next edge.
REQ-025 A WAIT cycle counter SHALL clear on entry; if TIMEOUT cycles elapse without isq_valid_in, the block SHALL pulse timeout_out, deliver no response and return to IDLE.
REQ-026 isq_valid_in in IDLE, ISSUE or RESP SHALL be ignored (late or stray results are discarded).
REQ-027 RESP SHALL hold resp_valid_out[g]=1 and resp_data_out stable until resp_ready_in[g]=1, then return to IDLE; resp_ready_in of other indices SHALL be ignored.
REQ-028 Only one operation SHALL be outstanding at a time; req_ready_out SHALL be zero outside IDLE.
REQ-029 Latency: accept at cycle T, isq_valid_out at T+1, resp_valid_out asserted the cycle after isq_valid_in is sampled; bypass gives resp_valid_out at T+1.
REQ-030 The block SHALL perform no arithmetic on results; data passes unmodified.

Reset
REQ-031 While rst_in=1, all outputs SHALL be 0, the state SHALL be IDLE, the counter SHALL be 0 and last_grant SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-032 Reset asserted mid-operation SHALL abort immediately; any subsequent unit result SHALL be discarded per REQ-026.

Verification
REQ-033 Single request: req 0 with 0x00008000 (0.5), unit model returns 0x00016A0A after 20 cycles -> resp_valid_out=4'b0001 and resp_data_out=0x00016A0A held until resp_ready_in[0].
REQ-034 Fairness: all four requesters held valid with operand 1.0 -> grant order 0,1,2,3,0; no index is granted twice before all others are served.
REQ-035 Bypass: req 2 with 0x00000000, then 0xFFFF0000 -> no isq_valid_out pulse; resp_data_out=0x7FFFFFFF both times.
REQ-036 Timeout: unit never returns -> timeout_out pulses exactly TIMEOUT cycles after WAIT entry, FSM returns to IDLE, and a late isq_valid_in produces no resp_valid_out.
REQ-037 Backpressure: resp_ready_in[1] held low for 10 cycles with req 1 granted -> resp_valid_out and resp_data_out stable; resp_ready_in[3]=1 meanwhile has no effect.
REQ-038 Reset in WAIT: assert rst_in -> all outputs 0 at once; after release, a new request from requester 0 is granted first.
